// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Iterative binary-to-BCD/ASCII converter built on the shift-add-3 (double
// dabble) method, one input bit per clock. It takes the integer quotient from
// the temperature scaling divider and produces LCD-ready characters.
//
// A conversion takes IN_WIDTH+2 cycles from the start edge to the next start
// edge. The flow is one load edge, IN_WIDTH shift edges and one result edge.
// The scratch register holds only DIGITS digits. Carries out of the top digit
// are dropped, so the BCD result is bin mod 10^DIGITS. A separate overflow
// flag is computed at load time.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   conversion request, honoured only while busy=0
//   bin    in   [IN_WIDTH-1:0] unsigned value, latched on accepted start
//   busy   out  conversion in progress
//   done   out  one-cycle pulse, bcd/ascii/ovf valid and freshly updated
//   bcd    out  [4*DIGITS-1:0] packed BCD, LSD in [3:0]
//   ascii  out  [8*DIGITS-1:0] characters, LSD char in [7:0]
//   ovf    out  latched value >= 10^DIGITS (all characters shown as '-')
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4,
  parameter int BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   ascii,
  output logic                  ovf
);

  localparam int CNT_W = (IN_WIDTH < 2) ? 1 : $clog2(IN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int ASC_W = 8 * DIGITS;

  // Saturating 10^n keeps the overflow limit meaningful for any DIGITS.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (r > 64'd1844674407370955161) r = '1;
      else                              r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  // Add 3 to every digit >= 5 before the shift. This is the double dabble
  // correction, so the doubled digit carries properly into the next one.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Character image of a BCD word. Leading-zero blanking walks down from the
  // MSD and stops at the first nonzero digit. The LSD is always printed.
  function automatic logic [ASC_W-1:0] build_ascii(input logic [BCD_W-1:0] b,
                                                   input logic             o);
    logic [ASC_W-1:0] r;
    logic             lead;
    logic [3:0]       d;
    r    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (o) begin
        r[8*i +: 8] = 8'h2D;
      end else if ((BLANK != 0) && lead && (d == 4'd0) && (i != 0)) begin
        r[8*i +: 8] = 8'h20;
      end else begin
        r[8*i +: 8] = 8'h30 + {4'h0, d};
        lead        = 1'b0;
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]      scr_q, scr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovfp_q, ovfp_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [ASC_W-1:0]      ascii_q, ascii_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [BCD_W-1:0]      adj;

  assign adj = add3(scr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      bcd_q   <= '0;
      ascii_q <= {DIGITS{8'h20}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      bcd_q   <= bcd_d;
      ascii_q <= ascii_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    bcd_d   = bcd_q;
    ascii_d = ascii_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_WIDTH);
          ovfp_d  = (64'(bin) >= LIMIT);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The top bit of the adjusted scratch falls off. That drop is the
        // mod 10^DIGITS truncation.
        scr_d = {adj[BCD_W-2:0], sr_q[IN_WIDTH-1]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        bcd_d   = scr_q;
        ovf_d   = ovfp_q;
        ascii_d = build_ascii(scr_q, ovfp_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ascii = ascii_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int IW     = 14;
  localparam int D      = 4;
  localparam int PERIOD = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] bin;
  logic          busy;
  logic          done;
  logic [4*D-1:0] bcd;
  logic [8*D-1:0] ascii;
  logic          ovf;

  bin_to_bcd_seq #(.IN_WIDTH(IW), .DIGITS(D), .BLANK(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ascii (ascii),
    .ovf   (ovf)
  );

  always #(PERIOD/2) clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [31:0] ascii;
    logic        ovf;
    longint      t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Caller must be positioned at a negedge; start is accepted on the next posedge.
  task automatic do_start(input logic [IW-1:0] v, input logic [15:0] eb,
                          input logic [31:0] ea, input logic eo);
    exp_t e;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    e.bcd = eb; e.ascii = ea; e.ovf = eo; e.t = longint'($time);
    sb.push_back(e);
    #1;
    start = 1'b0;
    bin   = '1;
  endtask

  // Returns at a negedge where done is high.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for done, got 0 expected 1", nm);
    end
  endtask

  // Scoreboard monitor
  exp_t   m_e;
  logic   prev_done = 1'b0;
  longint lat;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_width", {63'b0, prev_done}, 64'd0);
        check("busy_at_done", {63'b0, busy}, 64'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got bcd=%0h expected no done", bcd);
        end else begin
          m_e = sb.pop_front();
          check("bcd", {48'b0, bcd}, {48'b0, m_e.bcd});
          check("ascii", {32'b0, ascii}, {32'b0, m_e.ascii});
          check("ovf", {63'b0, ovf}, {63'b0, m_e.ovf});
          // done goes high right after edge k+IW+1.
          lat = (longint'($time) - 1 - m_e.t) / PERIOD;
          check("latency", 64'(lat), 64'(IW + 1));
        end
      end
      prev_done = done;
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_bcd", {48'b0, bcd}, 64'h0);
    check("rst_ovf", {63'b0, ovf}, 64'd0);
    check("rst_ascii", {32'b0, ascii}, 64'h20202020);
    repeat (5) @(negedge clk);
    check("idle_busy", {63'b0, busy}, 64'd0);

    // Zero
    do_start(14'd0, 16'h0000, 32'h20202030, 1'b0);
    wait_done("zero");

    // 1234, then back-to-back 9999 issued in the done cycle
    @(negedge clk);
    do_start(14'd1234, 16'h1234, 32'h31323334, 1'b0);
    wait_done("d1234");
    do_start(14'd9999, 16'h9999, 32'h39393939, 1'b0);
    wait_done("d9999");

    // Overflow cases; results must hold during a conversion
    @(negedge clk);
    do_start(14'd10000, 16'h0000, 32'h2D2D2D2D, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_bcd", {48'b0, bcd}, 64'h9999);
    check("hold_busy", {63'b0, busy}, 64'd1);
    wait_done("d10000");
    @(negedge clk);
    do_start(14'd16383, 16'h6383, 32'h2D2D2D2D, 1'b1);
    wait_done("d16383");

    // start during busy is ignored
    @(negedge clk);
    do_start(14'd250, 16'h0250, 32'h20323530, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd77;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("d250");
    repeat (20) @(negedge clk);

    // Reset in the middle of SHIFT
    do_start(14'd8191, 16'h8191, 32'h38313931, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_bcd", {48'b0, bcd}, 64'h0);
    check("abort_ascii", {32'b0, ascii}, 64'h20202020);
    check("abort_ovf", {63'b0, ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle_busy", {63'b0, busy}, 64'd0);

    do_start(14'd42, 16'h0042, 32'h20203432, 1'b0);
    wait_done("d42");

    repeat (20) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
